// File: rtl/vip_sobel_edge_detect_8bit.sv
// ============================================================================
// vip_sobel_edge_detect_8bit : 3-stage Sobel magnitude/threshold + edge count
// Rev 1.0
// ============================================================================
`default_nettype none

module vip_sobel_edge_detect_8bit #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             matrix_frame_vsync,
  input  logic             matrix_frame_href,
  input  logic             matrix_frame_clken,
  input  logic [7:0]       matrix_p11,
  input  logic [7:0]       matrix_p12,
  input  logic [7:0]       matrix_p13,
  input  logic [7:0]       matrix_p21,
  input  logic [7:0]       matrix_p22,
  input  logic [7:0]       matrix_p23,
  input  logic [7:0]       matrix_p31,
  input  logic [7:0]       matrix_p32,
  input  logic [7:0]       matrix_p33,
  input  logic [7:0]       thresh,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [7:0]       post_img_mag,
  output logic [7:0]       post_img_bit,
  output logic [CNT_W-1:0] edge_count,
  output logic             frame_done
);

  logic [9:0]       gx_p, gx_n, gy_p, gy_n;
  logic [9:0]       ax, ay;
  logic [10:0]      mag_sum;
  logic [2:0]       vsync_d, href_d, clken_d;
  logic             vsync_prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit, fall, rise;

  // The centre pixel p22 has zero weight in both kernels.
  wire unused_p22 = ^matrix_p22;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_p <= '0;
      gx_n <= '0;
      gy_p <= '0;
      gy_n <= '0;
    end else begin
      gx_p <= {2'b0, matrix_p13} + {1'b0, matrix_p23, 1'b0} + {2'b0, matrix_p33};
      gx_n <= {2'b0, matrix_p11} + {1'b0, matrix_p21, 1'b0} + {2'b0, matrix_p31};
      gy_p <= {2'b0, matrix_p11} + {1'b0, matrix_p12, 1'b0} + {2'b0, matrix_p13};
      gy_n <= {2'b0, matrix_p31} + {1'b0, matrix_p32, 1'b0} + {2'b0, matrix_p33};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax <= '0;
      ay <= '0;
    end else begin
      ax <= (gx_p >= gx_n) ? (gx_p - gx_n) : (gx_n - gx_p);
      ay <= (gy_p >= gy_n) ? (gy_p - gy_n) : (gy_n - gy_p);
    end
  end

  assign mag_sum = {1'b0, ax} + {1'b0, ay};

  // href_d[1] travels alongside ax/ay, so it gates the stage-3 result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_img_mag <= '0;
      post_img_bit <= '0;
    end else if (!href_d[1]) begin
      post_img_mag <= '0;
      post_img_bit <= '0;
    end else begin
      post_img_mag <= (mag_sum > 11'd255) ? 8'hFF : mag_sum[7:0];
      post_img_bit <= (mag_sum > {3'b0, thresh}) ? 8'hFF : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= '0;
      href_d  <= '0;
      clken_d <= '0;
    end else begin
      vsync_d <= {vsync_d[1:0], matrix_frame_vsync};
      href_d  <= {href_d[1:0],  matrix_frame_href};
      clken_d <= {clken_d[1:0], matrix_frame_clken};
    end
  end

  assign post_frame_vsync = vsync_d[2];
  assign post_frame_href  = href_d[2];
  assign post_frame_clken = clken_d[2];

  assign hit     = post_frame_vsync & post_frame_href & post_frame_clken & post_img_bit[0];
  assign cnt_inc = (hit && (cnt != {CNT_W{1'b1}})) ? (cnt + 1'b1) : cnt;
  assign fall    = vsync_prev & ~post_frame_vsync;
  assign rise    = ~vsync_prev & post_frame_vsync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev <= 1'b0;
      cnt        <= '0;
      edge_count <= '0;
      frame_done <= 1'b0;
    end else begin
      vsync_prev <= post_frame_vsync;
      frame_done <= fall;
      if (fall) begin
        edge_count <= cnt_inc;
        cnt        <= '0;
      end else if (rise) begin
        cnt <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vip_sobel_edge_detect_8bit.sv
// ============================================================================
// tb_vip_sobel_edge_detect_8bit : vector table + scoreboard bench for Sobel
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vip_sobel_edge_detect_8bit;

  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vsync = 1'b0, href = 1'b0, clken = 1'b0;
  logic [7:0]       p [9];
  logic [7:0]       thresh = 8'h00;
  logic             post_vsync, post_href, post_clken;
  logic [7:0]       post_img_mag, post_img_bit;
  logic [CNT_W-1:0] edge_count;
  logic             frame_done;

  always #5 clk = ~clk;

  vip_sobel_edge_detect_8bit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .matrix_frame_vsync(vsync), .matrix_frame_href(href), .matrix_frame_clken(clken),
    .matrix_p11(p[0]), .matrix_p12(p[1]), .matrix_p13(p[2]),
    .matrix_p21(p[3]), .matrix_p22(p[4]), .matrix_p23(p[5]),
    .matrix_p31(p[6]), .matrix_p32(p[7]), .matrix_p33(p[8]),
    .thresh(thresh),
    .post_frame_vsync(post_vsync), .post_frame_href(post_href), .post_frame_clken(post_clken),
    .post_img_mag(post_img_mag), .post_img_bit(post_img_bit),
    .edge_count(edge_count), .frame_done(frame_done)
  );

  typedef struct {
    logic [10:0] mag;
    logic        vs, hr, ck;
  } exp_t;

  typedef struct {
    logic [7:0] w [9];
    logic [7:0] th;
    logic       hr;
    logic [7:0] e_mag, e_bit;
  } vec_t;

  exp_t sbq [$];
  int   n_vec = 0, n_err = 0, fd_cnt = 0;

  // Reference model state for the post-pipeline edge counter.
  int   m_cnt = 0, m_edge = 0;
  logic m_fd = 1'b0, m_vprev = 1'b0;
  logic prev_vs = 1'b0, prev_hr = 1'b0, prev_ck = 1'b0;
  logic [7:0] prev_bit = 8'h00;

  function automatic logic [10:0] sobel(input logic [7:0] w [9]);
    int gxp, gxn, gyp, gyn, ax, ay;
    gxp = w[2] + 2 * w[5] + w[8];
    gxn = w[0] + 2 * w[3] + w[6];
    gyp = w[0] + 2 * w[1] + w[2];
    gyn = w[6] + 2 * w[7] + w[8];
    ax  = (gxp > gxn) ? gxp - gxn : gxn - gxp;
    ay  = (gyp > gyn) ? gyp - gyn : gyn - gyp;
    return 11'(ax + ay);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sbq.delete();
    m_cnt = 0; m_edge = 0; m_fd = 1'b0; m_vprev = 1'b0;
    prev_vs = 1'b0; prev_hr = 1'b0; prev_ck = 1'b0; prev_bit = 8'h00;
  endtask

  task automatic step(input logic vs, input logic hr, input logic ck);
    exp_t e, cur;
    logic [7:0] e_mag, e_bit;
    logic q, fall, rise;
    int inc;
    vsync = vs; href = hr; clken = ck;
    e.mag = sobel(p); e.vs = vs; e.hr = hr; e.ck = ck;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
    q    = prev_vs & prev_hr & prev_ck & prev_bit[0];
    inc  = (q && m_cnt != MAXC) ? m_cnt + 1 : m_cnt;
    fall = m_vprev & ~prev_vs;
    rise = ~m_vprev & prev_vs;
    m_fd = fall;
    if (fall) begin
      m_edge = inc; m_cnt = 0;
    end else if (rise) begin
      m_cnt = 0;
    end else begin
      m_cnt = inc;
    end
    m_vprev = prev_vs;
    cur = '{mag: 11'd0, vs: 1'b0, hr: 1'b0, ck: 1'b0};
    if (sbq.size() == 3) cur = sbq.pop_front();
    e_mag = 8'h00; e_bit = 8'h00;
    if (cur.hr) begin
      e_mag = (cur.mag > 11'd255) ? 8'hFF : cur.mag[7:0];
      e_bit = (cur.mag > {3'b0, thresh}) ? 8'hFF : 8'h00;
    end
    chk("sync", {post_vsync, post_href, post_clken}, {cur.vs, cur.hr, cur.ck});
    chk("mag", post_img_mag, e_mag);
    chk("bit", post_img_bit, e_bit);
    chk("edge_count", edge_count, m_edge);
    chk("frame_done", frame_done, m_fd);
    prev_vs = cur.vs; prev_hr = cur.hr; prev_ck = cur.ck; prev_bit = e_bit;
  endtask

  task automatic set_win(input logic [7:0] w [9]);
    for (int i = 0; i < 9; i++) p[i] = w[i];
  endtask

  task automatic pixel(input logic is_edge);
    logic [7:0] flat [9], vstep [9];
    flat  = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    vstep = '{8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF};
    thresh = 8'd100;
    set_win(is_edge ? vstep : flat);
    step(1'b1, 1'b1, 1'b1);
  endtask

  task automatic frame(input logic [15:0] pat);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int ln = 0; ln < 4; ln++) begin
      for (int px = 0; px < 4; px++) pixel(pat[ln * 4 + px]);
      if (ln < 3) step(1'b1, 1'b0, 1'b0);
    end
    repeat (5) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_check();
    rst_n = 1'b0;
    #2;
    chk("rst_sync", {post_vsync, post_href, post_clken}, 3'b000);
    chk("rst_mag", post_img_mag, 8'h00);
    chk("rst_bit", post_img_bit, 8'h00);
    chk("rst_edge_count", edge_count, 0);
    chk("rst_frame_done", frame_done, 1'b0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [12];

  initial begin
    for (int i = 0; i < 9; i++) p[i] = 8'h00;
    tbl[0]  = '{w: '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80}, th: 8'h10, hr: 1'b1, e_mag: 8'h00, e_bit: 8'h00};
    tbl[1]  = '{w: '{8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF}, th: 8'd100, hr: 1'b1, e_mag: 8'hFF, e_bit: 8'hFF};
    tbl[2]  = '{w: '{8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, th: 8'd128, hr: 1'b1, e_mag: 8'h80, e_bit: 8'h00};
    tbl[3]  = '{w: '{8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, th: 8'd127, hr: 1'b1, e_mag: 8'h80, e_bit: 8'hFF};
    tbl[4]  = '{w: '{8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF}, th: 8'd0, hr: 1'b0, e_mag: 8'h00, e_bit: 8'h00};
    tbl[5]  = '{w: '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, th: 8'hFF, hr: 1'b1, e_mag: 8'hFF, e_bit: 8'hFF};
    tbl[6]  = '{w: '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, th: 8'h00, hr: 1'b1, e_mag: 8'h00, e_bit: 8'h00};
    tbl[7]  = '{w: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00}, th: 8'h20, hr: 1'b1, e_mag: 8'h20, e_bit: 8'h00};
    tbl[8]  = '{w: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h30}, th: 8'h5F, hr: 1'b1, e_mag: 8'h60, e_bit: 8'hFF};
    tbl[9]  = '{w: '{8'h00, 8'h00, 8'h00, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, th: 8'h00, hr: 1'b1, e_mag: 8'hC0, e_bit: 8'hFF};
    tbl[10] = '{w: '{8'h00, 8'h7E, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, th: 8'hFE, hr: 1'b1, e_mag: 8'hFE, e_bit: 8'h00};
    tbl[11] = '{w: '{8'h00, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, th: 8'hFF, hr: 1'b1, e_mag: 8'hFF, e_bit: 8'hFF};

    #3;
    reset_check();

    // Each vector is held for the full latency so thresh is stable at stage 3.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      set_win(tbl[i].w);
      thresh = tbl[i].th;
      repeat (3) step(1'b1, tbl[i].hr, 1'b1);
      chk($sformatf("tbl%0d_mag", i), post_img_mag, tbl[i].e_mag);
      chk($sformatf("tbl%0d_bit", i), post_img_bit, tbl[i].e_bit);
    end
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // clken pattern 1,0,1 with href high, then href low with an edge window.
    set_win(tbl[1].w);
    thresh = 8'd10;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);

    fd_cnt = 0;
    frame(16'hB5B5);
    chk("frame10_edge_count", edge_count, 10);
    chk("frame10_done_pulses", fd_cnt, 1);

    // Mid-frame reset after five edges reach the counter.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pixel(i < 5);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    reset_check();
    repeat (3) step(1'b0, 1'b0, 1'b0);
    fd_cnt = 0;
    frame(16'h0007);
    chk("frame3_edge_count", edge_count, 3);
    chk("frame3_done_pulses", fd_cnt, 1);

    // Random frame, long enough to push the narrow counter into saturation.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 9; k++) p[k] = 8'($urandom_range(0, 255));
      thresh = 8'($urandom_range(0, 160));
      step(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    repeat (5) step(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
